plugboard_ctrl: RTL and testbench
=================================

# plugboard_ctrl

Sequencing controller for the Enigma plugboard stage. It walks the operator through entering up to 10 letter-swap pairs and stores them in a 26-entry swap table. In run mode, it translates the one-hot keyboard letter through that table before the letter enters the rotor/reflector path. It sits between the keyboard decoder and `rero`; a second instance, or a second lookup port, serves the rear plugboard.

## Interface
Parameters:
- `NUM_LETTERS`, 26, one-hot letter width.
- `MAX_PAIRS`, 10, maximum stored swap pairs.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset (driven by KEY[0]).
- `cfg_mode`  in  1  1 = configuration mode, 0 = run mode (driven by a switch).
- `key_valid`  in  1  single-cycle strobe; `key` is valid this cycle.
- `key`  in  26  one-hot letter for configuration entry; bit 0 = A … bit 25 = Z.
- `clear`  in  1  single-cycle strobe; erases all pairs (configuration mode only).
- `in_valid`  in  1  single-cycle strobe; `in` is valid this cycle.
- `in`  in  26  one-hot letter to translate (run mode).
- `out`  out  26  translated one-hot letter.
- `out_valid`  out  1  `out` is valid this cycle.
- `pair_count`  out  4  number of stored pairs, 0..10.
- `cfg_state`  out  2  current FSM state, for the GUI.
- `pending`  out  5  index of the first letter of the pair being entered; 0 when none.
- `err`  out  1  one-cycle pulse on a rejected entry.

## Operation
- Swap table: 26 entries of 5 bits each, `tbl[i]` = partner of letter i.
  - Reset or clear loads the identity mapping (`tbl[i] = i`).
  - Letter i is "paired" when `tbl[i] != i`.
- FSM states: RUN, CFG_FIRST, CFG_SECOND, CFG_WRITE.
  - RUN:
    - `cfg_mode = 1` → CFG_FIRST.
    - `in_valid` with one-hot `in` of index i → `out = onehot(tbl[i])`.
    - Non-one-hot `in` → `out = 0`, `out_valid = 1`.
  - CFG_FIRST, on `key_valid`:
    - Rejected (`err`, stay) if `key` is not one-hot, `key` is already paired, or `pair_count == MAX_PAIRS`.
    - Otherwise capture the index into `pending` → CFG_SECOND.
  - CFG_SECOND, on `key_valid`:
    - Rejected (`err`, stay) if `key` is not one-hot, `key` equals `pending`, or `key` is already paired.
    - Otherwise → CFG_WRITE.
  - CFG_WRITE:
    - Write `tbl[p] = q` and `tbl[q] = p`.
    - `pair_count` += 1, `pending` ← 0 → CFG_FIRST.
    - `key_valid` this cycle is dropped silently (no `err`).
- Leaving configuration: `cfg_mode = 0` in any CFG state → RUN next cycle.
  - A half-entered pair is discarded and `pending` ← 0.
  - A CFG_WRITE in progress completes first.
- `clear` in any CFG state:
  - Identity table, `pair_count` ← 0, `pending` ← 0 → CFG_FIRST.
  - `clear` beats a simultaneous `key_valid` and a pending write.
  - `clear` in RUN is ignored.
- In CFG states: `in_valid` is ignored and `out_valid` stays 0.
- `cfg_state` encoding: RUN = 0, CFG_FIRST = 1, CFG_SECOND = 2, CFG_WRITE = 3.
- Reset values:
  - FSM = RUN; table = identity.
  - `out = 0`, `out_valid = 0`, `pair_count = 0`, `pending = 0`, `err = 0`, `cfg_state = 0`.

## Timing
- All outputs are registered; reset acts asynchronously on assertion, and release is synchronous to `CLOCK_50`.
- Translation latency is exactly 1 cycle: `in_valid` at cycle n gives `out`/`out_valid` at n+1. Throughput is 1 letter per cycle.
- `out_valid` is a single-cycle pulse; `out` holds its last value afterwards.
- A pair entry takes 3 cycles minimum (key1, key2, write). The table and `pair_count` update on the CFG_WRITE edge.
- `err` asserts the cycle after the offending strobe, for 1 cycle.
- A translation issued in the first RUN cycle after configuration sees the fully written table.
- Back-to-back `key_valid` is legal; each is evaluated in the state current at its edge.

## Structure
- Shared package `enigma_pkg`:
  - `NUM_LETTERS` and `MAX_PAIRS`.
  - `cfg_state` encodings.
  - Letter index width (5).
- Sub-module `onehot_to_idx`: 26-bit one-hot → 5-bit index plus a `valid` flag (exactly one bit set).
  - Instantiated twice, for `key` and `in`.
  - Reusable by `rero` and `gui`.
- Table as flops (26×5); no RAM inference.

## Test plan
- Reset, RUN, `in = A` (bit 0) with `in_valid` → next cycle `out = A`, `out_valid = 1`, `pair_count = 0`.
- Configure A–Q: `cfg_mode = 1`, key A, key Q, wait 1 cycle, `cfg_mode = 0`; then `in = A` → `out` bit 16 (Q), and `in = Q` → `out` bit 0 (A). `pair_count = 1`.
- Rejections:
  - With A–Q stored, key A in CFG_FIRST → `err` pulse, state stays 1.
  - Key B then key B → `err`, state stays 2.
  - Key `26'h0000003` → `err`.
- Full: enter 10 valid pairs → `pair_count = 10`; an 11th first key → `err`, table unchanged.
- Abort: key C then `cfg_mode = 0` → RUN, `pending = 0`, C translates to C.
- Clear: `clear` and `key_valid` in the same cycle with 3 pairs stored → `pair_count = 0`, identity mapping for all 26 letters, state CFG_FIRST. Then assert `reset` low mid-entry → all outputs at reset values immediately.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma datapath blocks.
// The plugboard, rotor/reflector and GUI logic all use letter indices of the same width.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int MAX_PAIRS   = 10;
  localparam int IDX_W       = 5;
  localparam int COUNT_W     = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CFG_FIRST  = 2'd1,
    CFG_SECOND = 2'd2,
    CFG_WRITE  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot letter to binary index. valid is high only when exactly one bit is set;
// idx is forced to 0 otherwise, so callers can index tables with it unconditionally.
module onehot_to_idx #(
  parameter int W  = 26,
  parameter int IW = 5
) (
  input  logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] enc;

  // NOTE: every signal assigned in always_comb gets a default first; otherwise a latch is inferred.
  always_comb begin
    enc = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) enc = enc | IW'(i);
    end
  end

  assign valid = (onehot != '0) && ((onehot & (onehot - W'(1))) == '0);
  assign idx   = valid ? enc : '0;

endmodule

// File: rtl/plugboard_ctrl.sv
// Plugboard controller: guided entry of up to MAX_PAIRS letter swaps into a flop-based
// swap table, and one-cycle translation of keyboard letters through that table in run mode.
module plugboard_ctrl
  import enigma_pkg::IDX_W, enigma_pkg::COUNT_W, enigma_pkg::cfg_state_e,
         enigma_pkg::RUN, enigma_pkg::CFG_FIRST, enigma_pkg::CFG_SECOND, enigma_pkg::CFG_WRITE;
#(
  parameter int NUM_LETTERS = enigma_pkg::NUM_LETTERS,
  parameter int MAX_PAIRS   = enigma_pkg::MAX_PAIRS
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   cfg_mode,
  input  logic                   key_valid,
  input  logic [NUM_LETTERS-1:0] key,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [NUM_LETTERS-1:0] in,
  output logic [NUM_LETTERS-1:0] out,
  output logic                   out_valid,
  output logic [COUNT_W-1:0]     pair_count,
  output logic [1:0]             cfg_state,
  output logic [IDX_W-1:0]       pending,
  output logic                   err
);

  cfg_state_e     state_q, state_d;
  logic [IDX_W-1:0] tbl [NUM_LETTERS];
  logic [IDX_W-1:0] second_q;

  logic [IDX_W-1:0] key_idx, in_idx;
  logic             key_onehot, in_onehot;
  logic             key_paired;
  logic             do_capture, do_second, do_write, do_clear, do_abort, reject;

  onehot_to_idx #(.W(NUM_LETTERS), .IW(IDX_W)) u_key_dec (
    .onehot(key), .idx(key_idx), .valid(key_onehot)
  );

  onehot_to_idx #(.W(NUM_LETTERS), .IW(IDX_W)) u_in_dec (
    .onehot(in), .idx(in_idx), .valid(in_onehot)
  );

  assign key_paired = tbl[key_idx] != key_idx;
  assign cfg_state  = state_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Priority in config states: clear, then a write in flight, then leaving, then key entry.
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_second  = 1'b0;
    do_write   = 1'b0;
    do_clear   = 1'b0;
    do_abort   = 1'b0;
    reject     = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_mode) state_d = CFG_FIRST;
      end
      default: begin
        if (clear) begin
          do_clear = 1'b1;
          state_d  = cfg_mode ? CFG_FIRST : RUN;
        end else if (state_q == CFG_WRITE) begin
          do_write = 1'b1;
          state_d  = cfg_mode ? CFG_FIRST : RUN;
        end else if (!cfg_mode) begin
          do_abort = 1'b1;
          state_d  = RUN;
        end else if (key_valid) begin
          if (state_q == CFG_FIRST) begin
            if (!key_onehot || key_paired || pair_count == COUNT_W'(MAX_PAIRS)) begin
              reject = 1'b1;
            end else begin
              do_capture = 1'b1;
              state_d    = CFG_SECOND;
            end
          end else begin
            if (!key_onehot || key_idx == pending || key_paired) begin
              reject = 1'b1;
            end else begin
              do_second = 1'b1;
              state_d   = CFG_WRITE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      // NOTE: the table is plain flops, so it can and must be reset to identity here.
      for (int i = 0; i < NUM_LETTERS; i++) tbl[i] <= IDX_W'(i);
      pair_count <= '0;
      pending    <= '0;
      second_q   <= '0;
      err        <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
    end else begin
      err       <= reject;
      out_valid <= (state_q == RUN) && in_valid;
      if (state_q == RUN && in_valid) begin
        out <= in_onehot ? (NUM_LETTERS'(1) << tbl[in_idx]) : '0;
      end

      if (do_clear) begin
        for (int i = 0; i < NUM_LETTERS; i++) tbl[i] <= IDX_W'(i);
        pair_count <= '0;
        pending    <= '0;
      end else if (do_write) begin
        tbl[pending]  <= second_q;
        tbl[second_q] <= pending;
        pair_count    <= pair_count + COUNT_W'(1);
        pending       <= '0;
      end else if (do_abort) begin
        pending <= '0;
      end else if (do_capture) begin
        pending <= key_idx;
      end

      if (do_second) second_q <= key_idx;
    end
  end

endmodule

// File: tb/tb_plugboard_ctrl.sv
// Bench for plugboard_ctrl: scenario tasks with randomized pairs and letters,
// checked against a partner-array model of the plugboard.
module tb_plugboard_ctrl;

  logic        clk = 1'b0;
  logic        reset, cfg_mode, key_valid, clear, in_valid;
  logic [25:0] key, in_l, out_l;
  logic        out_valid, err;
  logic [3:0]  pair_count;
  logic [1:0]  cfg_state;
  logic [4:0]  pending;

  int checks   = 0;
  int failures = 0;
  int partner[26];
  int pairs;

  always #5 clk = ~clk;

  plugboard_ctrl dut (
    .CLOCK_50(clk), .reset(reset), .cfg_mode(cfg_mode), .key_valid(key_valid),
    .key(key), .clear(clear), .in_valid(in_valid), .in(in_l), .out(out_l),
    .out_valid(out_valid), .pair_count(pair_count), .cfg_state(cfg_state),
    .pending(pending), .err(err)
  );

  function automatic logic [25:0] letter(int i);
    logic [25:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [25:0] model_xlate(logic [25:0] l);
    int n   = 0;
    int idx = 0;
    for (int i = 0; i < 26; i++) if (l[i]) begin n++; idx = i; end
    if (n != 1) return '0;
    return letter(partner[idx]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 26; i++) partner[i] = i;
    pairs = 0;
  endfunction

  function automatic int pick_free(int a, int b);
    int fq[$];
    for (int i = 0; i < 26; i++) if (partner[i] == i && i != a && i != b) fq.push_back(i);
    return fq[$urandom_range(fq.size() - 1)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [25:0] k);
    key = k; key_valid = 1'b1;
    step();
    key_valid = 1'b0; key = '0;
  endtask

  task automatic xlate(input logic [25:0] l);
    in_l = l; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_l = '0;
  endtask

  task automatic enter_pair(input int p, input int q, input bit drop_key);
    press(letter(p));
    checks++;
    if (cfg_state !== 2'd2 || pending !== 5'(p)) begin
      failures++;
      $display("FAIL first_key: state=%0d pending=%0d, want state=2 pending=%0d", cfg_state, pending, p);
    end
    press(letter(q));
    checks++;
    if (cfg_state !== 2'd3) begin
      failures++;
      $display("FAIL second_key: state=%0d, want 3", cfg_state);
    end
    if (drop_key) begin
      key = letter(pick_free(p, q)); key_valid = 1'b1;
    end
    step();
    key_valid = 1'b0; key = '0;
    partner[p] = q; partner[q] = p; pairs++;
    checks++;
    if (cfg_state !== 2'd1 || pair_count !== 4'(pairs) || pending !== 5'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL write: state=%0d count=%0d pending=%0d err=%b, want 1 %0d 0 0",
               cfg_state, pair_count, pending, err, pairs);
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({out_l, out_valid, pair_count, cfg_state, pending, err} !== '0) begin
      failures++;
      $display("FAIL reset_values: out=%h v=%b cnt=%0d st=%0d pend=%0d err=%b, want all 0",
               out_l, out_valid, pair_count, cfg_state, pending, err);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_run_basic();
    logic [25:0] l, last;
    xlate(letter(0));
    checks++;
    if (out_l !== letter(0) || out_valid !== 1'b1 || pair_count !== 4'd0) begin
      failures++;
      $display("FAIL run_a: out=%h v=%b cnt=%0d, want %h 1 0", out_l, out_valid, pair_count, letter(0));
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_l !== letter(0)) begin
      failures++;
      $display("FAIL out_hold: out=%h v=%b, want %h 0", out_l, out_valid, letter(0));
    end
    for (int n = 0; n < 12; n++) begin
      case (n % 3)
        0:       l = letter($urandom_range(25));
        1:       l = 26'($urandom);
        default: l = (n == 5) ? 26'd0 : letter($urandom_range(25));
      endcase
      xlate(l);
      checks++;
      if (out_l !== model_xlate(l) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL run_rand: in=%h out=%h v=%b, want %h 1", l, out_l, out_valid, model_xlate(l));
      end
    end
    last = out_l;
  endtask

  task automatic test_translate_all(input string tag);
    for (int i = 0; i < 26; i++) begin
      xlate(letter(i));
      checks++;
      if (out_l !== model_xlate(letter(i)) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL xlate_%s: letter=%0d out=%h v=%b, want %h 1", tag, i, out_l, out_valid,
                 model_xlate(letter(i)));
      end
    end
  endtask

  task automatic test_config_aq();
    cfg_mode = 1'b1;
    step();
    checks++;
    if (cfg_state !== 2'd1) begin
      failures++;
      $display("FAIL enter_cfg: state=%0d, want 1", cfg_state);
    end
    xlate(letter(5));
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cfg_ignores_in: out_valid=%b, want 0", out_valid);
    end
    enter_pair(0, 16, 1'b0);
    cfg_mode = 1'b0;
    step();
    checks++;
    if (cfg_state !== 2'd0) begin
      failures++;
      $display("FAIL leave_cfg: state=%0d, want 0", cfg_state);
    end
    xlate(letter(0));
    xlate(letter(16));
    checks++;
    if (out_l !== letter(0) || pair_count !== 4'd1) begin
      failures++;
      $display("FAIL aq_swap: out=%h cnt=%0d, want %h 1", out_l, pair_count, letter(0));
    end
    test_translate_all("aq");
  endtask

  task automatic test_rejections();
    cfg_mode = 1'b1;
    step();
    press(letter(0));
    checks++;
    if (err !== 1'b1 || cfg_state !== 2'd1) begin
      failures++;
      $display("FAIL rej_paired: err=%b state=%0d, want 1 1", err, cfg_state);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: err=%b, want 0", err);
    end
    press(letter(1));
    press(letter(1));
    checks++;
    if (err !== 1'b1 || cfg_state !== 2'd2 || pending !== 5'd1) begin
      failures++;
      $display("FAIL rej_same: err=%b state=%0d pend=%0d, want 1 2 1", err, cfg_state, pending);
    end
    press(26'h0000003);
    checks++;
    if (err !== 1'b1 || cfg_state !== 2'd2 || pair_count !== 4'd1) begin
      failures++;
      $display("FAIL rej_multi: err=%b state=%0d cnt=%0d, want 1 2 1", err, cfg_state, pair_count);
    end
    cfg_mode = 1'b0;
    step();
  endtask

  task automatic test_abort();
    cfg_mode = 1'b1;
    step();
    press(letter(2));
    checks++;
    if (pending !== 5'd2 || cfg_state !== 2'd2) begin
      failures++;
      $display("FAIL abort_capture: pend=%0d state=%0d, want 2 2", pending, cfg_state);
    end
    cfg_mode = 1'b0;
    step();
    checks++;
    if (cfg_state !== 2'd0 || pending !== 5'd0) begin
      failures++;
      $display("FAIL abort_exit: state=%0d pend=%0d, want 0 0", cfg_state, pending);
    end
    xlate(letter(2));
    checks++;
    if (out_l !== letter(2) || pair_count !== 4'd1) begin
      failures++;
      $display("FAIL abort_xlate: out=%h cnt=%0d, want %h 1", out_l, pair_count, letter(2));
    end
  endtask

  task automatic test_full_table();
    int p, q, r;
    cfg_mode = 1'b1;
    step();
    while (pairs < 10) begin
      p = pick_free(-1, -1);
      q = pick_free(p, -1);
      enter_pair(p, q, pairs == 1);
    end
    r = pick_free(-1, -1);
    press(letter(r));
    checks++;
    if (err !== 1'b1 || cfg_state !== 2'd1 || pair_count !== 4'd10) begin
      failures++;
      $display("FAIL full_reject: err=%b state=%0d cnt=%0d, want 1 1 10", err, cfg_state, pair_count);
    end
    cfg_mode = 1'b0;
    step();
    test_translate_all("full");
  endtask

  task automatic test_clear();
    int p, q;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (pair_count !== 4'd10 || cfg_state !== 2'd0) begin
      failures++;
      $display("FAIL clear_in_run: cnt=%0d state=%0d, want 10 0", pair_count, cfg_state);
    end
    cfg_mode = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    for (int n = 0; n < 3; n++) begin
      p = pick_free(-1, -1);
      q = pick_free(p, -1);
      enter_pair(p, q, 1'b0);
    end
    p = pick_free(-1, -1);
    q = pick_free(p, -1);
    press(letter(p));
    press(letter(q));
    clear = 1'b1; key_valid = 1'b1; key = letter(pick_free(p, q));
    step();
    clear = 1'b0; key_valid = 1'b0; key = '0;
    model_clear();
    checks++;
    if (pair_count !== 4'd0 || cfg_state !== 2'd1 || pending !== 5'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL clear_cfg: cnt=%0d state=%0d pend=%0d err=%b, want 0 1 0 0",
               pair_count, cfg_state, pending, err);
    end
    cfg_mode = 1'b0;
    step();
    test_translate_all("cleared");
  endtask

  task automatic test_reset_mid_entry();
    cfg_mode = 1'b1;
    step();
    press(letter(3));
    checks++;
    if (pending !== 5'd3 || cfg_state !== 2'd2) begin
      failures++;
      $display("FAIL mid_entry: pend=%0d state=%0d, want 3 2", pending, cfg_state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_l, out_valid, pair_count, cfg_state, pending, err} !== '0) begin
      failures++;
      $display("FAIL async_reset: out=%h v=%b cnt=%0d st=%0d pend=%0d err=%b, want all 0",
               out_l, out_valid, pair_count, cfg_state, pending, err);
    end
    step();
    reset = 1'b1; cfg_mode = 1'b0;
    step();
    xlate(letter(3));
    checks++;
    if (out_l !== letter(3) || out_valid !== 1'b1 || cfg_state !== 2'd0) begin
      failures++;
      $display("FAIL post_reset: out=%h v=%b st=%0d, want %h 1 0", out_l, out_valid, cfg_state, letter(3));
    end
  endtask

  initial begin
    reset = 1'b0; cfg_mode = 1'b0; key_valid = 1'b0; clear = 1'b0; in_valid = 1'b0;
    key = '0; in_l = '0;
    model_clear();
    test_reset();
    test_run_basic();
    test_config_aq();
    test_rejections();
    test_abort();
    test_full_table();
    test_clear();
    test_reset_mid_entry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
